alu_cmd_master: RTL and testbench

- Drives the ALU_TOP datapath from a byte stream and returns the results as a byte stream.
- Collects a command frame (function byte, then operand A and B bytes), presents A/B/ALU_FUNC to the ALU, and captures the result of the enabled unit.
- Sends back a status byte plus result bytes over a valid/ready handshake.
- Sits between the serial/byte front end and the ALU as its initiator, in the functional clock domain.

---
 rtl/alu_cmd_master.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_cmd_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// alu_cmd_master
// Byte-stream front end for the ALU datapath. A request frame is one command
// byte ({4'b0, func}), then NB bytes of operand A and NB bytes of operand B,
// each sent LSB first. The block presents A/B/ALU_FUNC to the ALU and waits
// one cycle while the ALU registers them. It then captures the result of the
// unit selected by func[3:2] and returns a status byte followed by the result
// bytes, LSB first.
//
// Ports
//   CLK, RST                  functional clock, synchronous active-high reset
//   RX_DATA/RX_VALID/RX_READY request byte stream (valid/ready)
//   A, B, ALU_FUNC            operands and function code driven to the ALU
//   ARITH_OUT..CMP_FLAG       ALU unit results and flags
//   TX_DATA/TX_VALID/TX_READY response byte stream (valid/ready)
//   BUSY                      high whenever a frame is in progress
//   FRAME_ERR                 one-cycle pulse when a frame is dropped
module alu_cmd_master #(
    parameter int OP_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [7:0]                 RX_DATA,
    input  logic                       RX_VALID,
    output logic                       RX_READY,
    output logic [OP_DATA_WIDTH-1:0]   A,
    output logic [OP_DATA_WIDTH-1:0]   B,
    output logic [3:0]                 ALU_FUNC,
    input  logic [2*OP_DATA_WIDTH-1:0] ARITH_OUT,
    input  logic                       CARRY_OUT,
    input  logic                       ARITH_FLAG,
    input  logic [OP_DATA_WIDTH-1:0]   LOGIC_OUT,
    input  logic                       LOGIC_FLAG,
    input  logic [OP_DATA_WIDTH-1:0]   SHIFT_OUT,
    input  logic                       SHIFT_FLAG,
    input  logic [2:0]                 CMP_OUT,
    input  logic                       CMP_FLAG,
    output logic [7:0]                 TX_DATA,
    output logic                       TX_VALID,
    input  logic                       TX_READY,
    output logic                       BUSY,
    output logic                       FRAME_ERR
);

    localparam int NB = OP_DATA_WIDTH / 8;
    localparam int RW = 2 * OP_DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(2 * NB + 1);

    localparam logic [CW-1:0] NB_LAST  = CW'(NB - 1);
    localparam logic [CW-1:0] TX_ARITH = CW'(2 * NB);
    localparam logic [CW-1:0] TX_OTHER = CW'(NB);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_ISSUE,
        S_CAPTURE,
        S_TX_STAT,
        S_TX_DATA
    } state_t;

    state_t                   state_q,    state_d;
    logic [3:0]               func_q,     func_d;
    logic [OP_DATA_WIDTH-1:0] a_sh_q,     a_sh_d;
    logic [OP_DATA_WIDTH-1:0] b_sh_q,     b_sh_d;
    logic [OP_DATA_WIDTH-1:0] a_out_q,    a_out_d;
    logic [OP_DATA_WIDTH-1:0] b_out_q,    b_out_d;
    logic [3:0]               alu_func_q, alu_func_d;
    logic [CW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]            tmo_cnt_q,  tmo_cnt_d;
    logic [RW-1:0]            result_q,   result_d;
    logic [CW-1:0]            tx_left_q,  tx_left_d;
    logic [7:0]               tx_data_q,  tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     frame_err_q, frame_err_d;

    logic                     rx_ready;
    logic                     rx_fire;
    logic [OP_DATA_WIDTH-1:0] a_shift_next;
    logic [OP_DATA_WIDTH-1:0] b_shift_next;
    logic [RW-1:0]            sel_result;
    logic                     sel_carry;
    logic                     sel_flag;

    // Request bytes arrive LSB first, so each new byte enters at the top of
    // the shift register and the first byte ends up in the low byte.
    assign a_shift_next = (a_sh_q >> 8) | (OP_DATA_WIDTH'(RX_DATA) << (OP_DATA_WIDTH - 8));
    assign b_shift_next = (b_sh_q >> 8) | (OP_DATA_WIDTH'(RX_DATA) << (OP_DATA_WIDTH - 8));

    assign rx_ready = (state_q == S_IDLE) || (state_q == S_RX_A) || (state_q == S_RX_B);
    assign rx_fire  = RX_VALID && rx_ready;

    // Result mux for the unit chosen by func[3:2]. Carry only has a meaning
    // for the arithmetic unit, so it is forced low for every other unit.
    always_comb begin
        sel_result = '0;
        sel_carry  = 1'b0;
        sel_flag   = 1'b0;
        case (func_q[3:2])
            2'b00: begin
                sel_result = ARITH_OUT;
                sel_carry  = CARRY_OUT;
                sel_flag   = ARITH_FLAG;
            end
            2'b01: begin
                sel_result = RW'(LOGIC_OUT);
                sel_flag   = LOGIC_FLAG;
            end
            2'b10: begin
                sel_result = RW'(CMP_OUT);
                sel_flag   = CMP_FLAG;
            end
            default: begin
                sel_result = RW'(SHIFT_OUT);
                sel_flag   = SHIFT_FLAG;
            end
        endcase
    end

    // Frame sequencer: next state and next register values.
    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        alu_func_d  = alu_func_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        result_d    = result_q;
        tx_left_d   = tx_left_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                if (rx_fire) begin
                    if (RX_DATA[7:4] != 4'd0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        func_d     = RX_DATA[3:0];
                        byte_cnt_d = '0;
                        state_d    = S_RX_A;
                    end
                end
            end

            S_RX_A: begin
                if (rx_fire) begin
                    a_sh_d    = a_shift_next;
                    tmo_cnt_d = '0;
                    if (byte_cnt_q == NB_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = S_RX_B;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_MAX) begin
                    // A byte arriving in this same cycle takes the branch
                    // above, so the timeout only fires on a silent cycle.
                    frame_err_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_RX_B: begin
                if (rx_fire) begin
                    b_sh_d    = b_shift_next;
                    tmo_cnt_d = '0;
                    if (byte_cnt_q == NB_LAST) begin
                        // The ALU-facing registers only change once a frame
                        // is complete, so a dropped frame never disturbs them.
                        byte_cnt_d = '0;
                        a_out_d    = a_sh_q;
                        b_out_d    = b_shift_next;
                        alu_func_d = func_q;
                        state_d    = S_ISSUE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_MAX) begin
                    frame_err_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_ISSUE: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                // Status byte is loaded here so it is on TX_DATA the very
                // first cycle of TX_STAT.
                result_d   = sel_result;
                tx_data_d  = {4'b0000, func_q[3:2], sel_carry, sel_flag};
                tx_valid_d = 1'b1;
                tx_left_d  = (func_q[3:2] == 2'b00) ? TX_ARITH : TX_OTHER;
                state_d    = S_TX_STAT;
            end

            S_TX_STAT: begin
                if (TX_READY) begin
                    tx_data_d = result_q[7:0];
                    result_d  = result_q >> 8;
                    state_d   = S_TX_DATA;
                end
            end

            S_TX_DATA: begin
                // tx_left counts result bytes not yet accepted, including
                // the one currently presented.
                if (TX_READY) begin
                    if (tx_left_q == CW'(1)) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'd0;
                        tx_left_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = result_q[7:0];
                        result_d  = result_q >> 8;
                        tx_left_d = tx_left_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame or response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            func_q      <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            alu_func_q  <= '0;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            result_q    <= '0;
            tx_left_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            alu_func_q  <= alu_func_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            result_q    <= result_d;
            tx_left_q   <= tx_left_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign RX_READY  = rx_ready;
    assign A         = a_out_q;
    assign B         = b_out_q;
    assign ALU_FUNC  = alu_func_q;
    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign BUSY      = (state_q != S_IDLE);
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master
// Randomized scoreboard bench for alu_cmd_master. A small registered ALU model
// answers the DUT's operands. Each issued frame pushes its expected response
// bytes, derived from the frame's function and operands, into a queue. A
// monitor pops and compares on every accepted TX byte and checks that held
// bytes stay stable.
module tb_alu_cmd_master;

    localparam int W   = 16;
    localparam int NB  = W / 8;
    localparam int TMO = 20;

    logic           CLK = 1'b0;
    logic           RST;
    logic [7:0]     RX_DATA;
    logic           RX_VALID;
    logic           RX_READY;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [3:0]     ALU_FUNC;
    logic [2*W-1:0] ARITH_OUT;
    logic           CARRY_OUT;
    logic           ARITH_FLAG;
    logic [W-1:0]   LOGIC_OUT;
    logic           LOGIC_FLAG;
    logic [W-1:0]   SHIFT_OUT;
    logic           SHIFT_FLAG;
    logic [2:0]     CMP_OUT;
    logic           CMP_FLAG;
    logic [7:0]     TX_DATA;
    logic           TX_VALID;
    logic           TX_READY;
    logic           BUSY;
    logic           FRAME_ERR;

    int         checks = 0;
    int         errors = 0;
    int         frameErrCount = 0;
    logic [7:0] expQ[$];
    logic [7:0] expByte;
    logic [7:0] heldData;
    bit         holdPending = 0;

    // TX_READY source: 0 = driven directly by the main sequence,
    // 1 = random, 2 = fixed backpressure pattern.
    int   txMode = 0;
    logic txManual = 1'b1;
    logic txAuto = 1'b1;
    int   patIdx = 0;
    bit   pat[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 1};

    assign TX_READY = (txMode == 0) ? txManual : txAuto;

    always #5 CLK = ~CLK;

    alu_cmd_master #(
        .OP_DATA_WIDTH(W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .A(A),
        .B(B),
        .ALU_FUNC(ALU_FUNC),
        .ARITH_OUT(ARITH_OUT),
        .CARRY_OUT(CARRY_OUT),
        .ARITH_FLAG(ARITH_FLAG),
        .LOGIC_OUT(LOGIC_OUT),
        .LOGIC_FLAG(LOGIC_FLAG),
        .SHIFT_OUT(SHIFT_OUT),
        .SHIFT_FLAG(SHIFT_FLAG),
        .CMP_OUT(CMP_OUT),
        .CMP_FLAG(CMP_FLAG),
        .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .BUSY(BUSY),
        .FRAME_ERR(FRAME_ERR)
    );

    // ALU behaviour used by both the ALU model and the expected-response model.
    function automatic logic [2*W-1:0] modelArith(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f[1:0])
            2'd0:    return {16'd0, a} + {16'd0, b};
            2'd1:    return {16'd0, a} - {16'd0, b};
            2'd2:    return {16'd0, a} * {16'd0, b};
            default: return {a, b};
        endcase
    endfunction

    function automatic logic modelCarry(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (f[1:0] == 2'd0) return s[W];
        if (f[1:0] == 2'd1) return (a < b);
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] modelLogic(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f[1:0])
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [W-1:0] modelShift(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f[1:0])
            2'd0:    return a >> 1;
            2'd1:    return a << 1;
            2'd2:    return a >> b[3:0];
            default: return a << b[3:0];
        endcase
    endfunction

    function automatic logic [2:0] modelCmp(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a < b, a > b, a == b};
    endfunction

    // ALU model: registers its inputs every cycle and drives every unit.
    // The carry is driven whatever unit is selected, so the DUT must mask it.
    always @(posedge CLK) begin
        ARITH_OUT  <= modelArith(ALU_FUNC, A, B);
        CARRY_OUT  <= modelCarry(ALU_FUNC, A, B);
        ARITH_FLAG <= modelArith(ALU_FUNC, A, B) & 32'd1 ? 1'b1 : 1'b0;
        LOGIC_OUT  <= modelLogic(ALU_FUNC, A, B);
        LOGIC_FLAG <= ^modelLogic(ALU_FUNC, A, B);
        SHIFT_OUT  <= modelShift(ALU_FUNC, A, B);
        SHIFT_FLAG <= (modelShift(ALU_FUNC, A, B) == '0);
        CMP_OUT    <= modelCmp(A, B);
        CMP_FLAG   <= (A != B);
    end

    // TX_READY generator for the random and pattern modes.
    always @(posedge CLK) begin
        #1;
        if (txMode == 2) begin
            if (TX_VALID) begin
                txAuto = (patIdx < 10) ? pat[patIdx] : 1'b1;
                patIdx = patIdx + 1;
            end
        end else if (txMode == 1) begin
            txAuto = 1'($urandom_range(0, 1));
            patIdx = 0;
        end else begin
            txAuto = 1'b1;
            patIdx = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares accepted bytes and checks held bytes.
    always @(negedge CLK) begin
        if (RST) begin
            holdPending = 0;
        end else begin
            if (holdPending) begin
                checkOutput("tx_hold_valid", 64'(TX_VALID), 64'd1);
                checkOutput("tx_hold_data", 64'(TX_DATA), 64'(heldData));
            end
            if (TX_VALID && TX_READY) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected: got byte 0x%02h required no byte", TX_DATA);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("tx_byte", 64'(TX_DATA), 64'(expByte));
                end
                holdPending = 0;
            end else if (TX_VALID) begin
                holdPending = 1;
                heldData = TX_DATA;
            end else begin
                holdPending = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (FRAME_ERR) frameErrCount++;
    end

    // Expected response for one valid frame, built from the unit rules.
    task automatic pushExpected(input logic [7:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [1:0]     unit;
        logic [2*W-1:0] res;
        logic           carry;
        logic           flag;
        int             n;
        unit  = cmd[3:2];
        carry = 1'b0;
        case (unit)
            2'b00: begin
                res   = modelArith(cmd[3:0], a, b);
                carry = modelCarry(cmd[3:0], a, b);
                flag  = res[0];
            end
            2'b01: begin
                res  = 32'(modelLogic(cmd[3:0], a, b));
                flag = ^res;
            end
            2'b10: begin
                res  = 32'(modelCmp(a, b));
                flag = (a != b);
            end
            default: begin
                res  = 32'(modelShift(cmd[3:0], a, b));
                flag = (res == '0);
            end
        endcase
        expQ.push_back({4'b0000, unit, carry, flag});
        n = (unit == 2'b00) ? 2 * NB : NB;
        for (int i = 0; i < n; i++) expQ.push_back(res[8*i +: 8]);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        RX_DATA = b;
        RX_VALID = 1'b1;
        while (!acc && n < 300) begin
            @(negedge CLK);
            acc = RX_READY;
            @(posedge CLK);
            #1;
            n++;
        end
        RX_VALID = 1'b0;
        if (!acc) checkOutput("rx_accept_wait", 64'd0, 64'd1);
    endtask

    // Sends one whole frame; optionally checks ISSUE outputs and latency.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b, input bit chkTiming);
        if (cmd[7:4] == 4'd0) pushExpected(cmd, a, b);
        sendByte(cmd);
        for (int i = 0; i < NB; i++) sendByte(a[8*i +: 8]);
        for (int i = 0; i < NB; i++) sendByte(b[8*i +: 8]);
        if (chkTiming) begin
            checkOutput("issue_alu_func", 64'(ALU_FUNC), 64'(cmd[3:0]));
            checkOutput("issue_a", 64'(A), 64'(a));
            checkOutput("issue_b", 64'(B), 64'(b));
            checkOutput("issue_rx_ready", 64'(RX_READY), 64'd0);
            checkOutput("issue_busy", 64'(BUSY), 64'd1);
            checkOutput("issue_tx_valid", 64'(TX_VALID), 64'd0);
            tick();
            checkOutput("capture_tx_valid", 64'(TX_VALID), 64'd0);
            tick();
            checkOutput("stat_tx_valid", 64'(TX_VALID), 64'd1);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
        tick();
        checkOutput("drain_busy", 64'(BUSY), 64'd0);
    endtask

    initial begin
        int n;
        int feBefore;
        logic [7:0] cmd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        RST = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA = 8'd0;
        repeat (3) tick();
        checkOutput("rst_a", 64'(A), 64'd0);
        checkOutput("rst_b", 64'(B), 64'd0);
        checkOutput("rst_alu_func", 64'(ALU_FUNC), 64'd0);
        checkOutput("rst_tx_valid", 64'(TX_VALID), 64'd0);
        checkOutput("rst_tx_data", 64'(TX_DATA), 64'd0);
        checkOutput("rst_frame_err", 64'(FRAME_ERR), 64'd0);
        checkOutput("rst_busy", 64'(BUSY), 64'd0);
        RST = 1'b0;
        tick();
        checkOutput("post_rst_rx_ready", 64'(RX_READY), 64'd1);

        $display("[TB] arithmetic frame");
        applyStimulus(8'h00, 16'h1234, 16'h0101, 1);
        waitDrain();

        $display("[TB] compare frame");
        applyStimulus(8'h08, 16'h0050, 16'h0020, 1);
        waitDrain();

        $display("[TB] backpressure frame");
        txMode = 2;
        applyStimulus(8'h04, 16'hBEEF, 16'hFFFF, 0);
        waitDrain();
        txMode = 0;
        txManual = 1'b1;

        $display("[TB] invalid command");
        sendByte(8'h37);
        checkOutput("invalid_frame_err", 64'(FRAME_ERR), 64'd1);
        checkOutput("invalid_rx_ready", 64'(RX_READY), 64'd1);
        checkOutput("invalid_busy", 64'(BUSY), 64'd0);
        tick();
        checkOutput("invalid_pulse_end", 64'(FRAME_ERR), 64'd0);

        $display("[TB] timeout");
        sendByte(8'h00);
        sendByte(8'hAA);
        repeat (TMO) tick();
        checkOutput("tmo_not_early", 64'(FRAME_ERR), 64'd0);
        checkOutput("tmo_busy_before", 64'(BUSY), 64'd1);
        tick();
        checkOutput("tmo_frame_err", 64'(FRAME_ERR), 64'd1);
        checkOutput("tmo_idle", 64'(BUSY), 64'd0);
        checkOutput("tmo_rx_ready", 64'(RX_READY), 64'd1);
        checkOutput("tmo_a_held", 64'(A), 64'hBEEF);
        applyStimulus(8'h01, 16'h0003, 16'h0005, 1);
        waitDrain();

        $display("[TB] byte on timeout boundary");
        feBefore = frameErrCount;
        pushExpected(8'h0F, 16'h00F0, 16'h0004);
        sendByte(8'h0F);
        sendByte(8'hF0);
        repeat (TMO) tick();
        sendByte(8'h00);
        sendByte(8'h04);
        repeat (TMO) tick();
        sendByte(8'h00);
        waitDrain();
        checkOutput("edge_no_frame_err", 64'(frameErrCount), 64'(feBefore));

        $display("[TB] reset mid-response");
        txManual = 1'b0;
        applyStimulus(8'h02, 16'h1234, 16'h5678, 0);
        n = 0;
        while (!TX_VALID && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rstmid_tx_valid_seen", 64'(TX_VALID), 64'd1);
        txManual = 1'b1;
        tick();
        tick();
        txManual = 1'b0;
        RST = 1'b1;
        expQ.delete();
        tick();
        checkOutput("rstmid_tx_valid", 64'(TX_VALID), 64'd0);
        checkOutput("rstmid_busy", 64'(BUSY), 64'd0);
        checkOutput("rstmid_a", 64'(A), 64'd0);
        checkOutput("rstmid_b", 64'(B), 64'd0);
        checkOutput("rstmid_alu_func", 64'(ALU_FUNC), 64'd0);
        checkOutput("rstmid_rx_ready", 64'(RX_READY), 64'd1);
        checkOutput("rstmid_frame_err", 64'(FRAME_ERR), 64'd0);
        RST = 1'b0;
        txManual = 1'b1;
        repeat (4) begin
            tick();
            checkOutput("rstmid_no_resume", 64'(TX_VALID), 64'd0);
        end

        $display("[TB] random frames");
        txMode = 1;
        for (int i = 0; i < 25; i++) begin
            cmd = 8'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(cmd, ra, rb, (i % 4) == 0);
        end
        waitDrain();
        txMode = 0;

        checkOutput("frame_err_total", 64'(frameErrCount), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
